// File: rtl/out_capture_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : out_capture_pkg                                                 |
// | Purpose  : Shared state type and default sizing for the CPU output         |
// |            capture unit.                                                   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package out_capture_pkg;

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } captureState_t;

  localparam int unsigned c_defaultWidth        = 36;
  localparam int unsigned c_defaultDepth        = 16;
  localparam int unsigned c_defaultCountWidth   = 16;
  localparam int unsigned c_defaultStartDelay   = 10;
  localparam int unsigned c_defaultCaptureLimit = 668;

endpackage : out_capture_pkg
`default_nettype wire

// File: rtl/out_capture_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface: out_capture_unit_if                                             |
// | Purpose  : CPU output strobe plus the valid/ready drain stream of the      |
// |            capture unit. With OUTCAPTURE_TIMESTAMP_EN defined the drain    |
// |            stream also carries the head entry's capture cycle.            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface out_capture_unit_if
  import out_capture_pkg::*;
#(
  parameter int unsigned WIDTH = c_defaultWidth
`ifdef OUTCAPTURE_TIMESTAMP_EN
  , parameter int unsigned COUNTWIDTH = c_defaultCountWidth
`endif
);

  logic             outFlag;
  logic [WIDTH-1:0] out;
  logic             dataValid;
  logic             dataReady;
  logic [WIDTH-1:0] dataOut;
`ifdef OUTCAPTURE_TIMESTAMP_EN
  logic [COUNTWIDTH-1:0] dataTimestamp;
`endif

  // master is the capture unit; slave is the CPU/consumer side
`ifdef OUTCAPTURE_TIMESTAMP_EN
  modport master (input outFlag, out, dataReady, output dataValid, dataOut, dataTimestamp);
  modport slave  (output outFlag, out, dataReady, input dataValid, dataOut, dataTimestamp);
`else
  modport master (input outFlag, out, dataReady, output dataValid, dataOut);
  modport slave  (output outFlag, out, dataReady, input dataValid, dataOut);
`endif

endinterface : out_capture_unit_if
`default_nettype wire

// File: rtl/out_capture_unit_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : capture_fifo                                                    |
// | Purpose  : Circular buffer with occupancy counter. A push into a full      |
// |            buffer is accepted only when a pop frees the slot in the same   |
// |            cycle. Head is read combinationally; no same-cycle fall-through.|
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module capture_fifo
  import out_capture_pkg::*;
#(
  parameter int unsigned WIDTH = c_defaultWidth,
  parameter int unsigned DEPTH = c_defaultDepth
) (
  input  wire logic                     clock,
  input  wire logic                     reset,
  input  wire logic                     push,
  input  wire logic [WIDTH-1:0]         pushData,
  input  wire logic                     pop,
  output logic                          full,
  output logic                          empty,
  output logic [WIDTH-1:0]              headData,
  output logic [$clog2(DEPTH):0]        occupancy
);

  localparam int unsigned c_ptrWidth = $clog2(DEPTH);
  localparam logic [c_ptrWidth:0] c_fullLevel = (c_ptrWidth+1)'(DEPTH);

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [c_ptrWidth-1:0] r_wrPtr;
  logic [c_ptrWidth-1:0] r_rdPtr;
  logic [c_ptrWidth:0]   r_occupancy;
  logic                  w_push;
  logic                  w_pop;

  assign full      = (r_occupancy == c_fullLevel);
  assign empty     = (r_occupancy == '0);
  assign w_pop     = pop && !empty;
  assign w_push    = push && (!full || w_pop);
  assign headData  = r_mem[r_rdPtr];
  assign occupancy = r_occupancy;

  // Storage array; contents are don't-care after reset, only pointers clear
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= pushData;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); occupancy tracks fill level
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_occupancy <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_occupancy <= r_occupancy + 1'b1;
        2'b01:   r_occupancy <= r_occupancy - 1'b1;
        default: r_occupancy <= r_occupancy;
      endcase
    end
  end

endmodule : capture_fifo
`default_nettype wire

// File: rtl/out_capture_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : out_capture_unit                                                |
// | Purpose  : Raises CPU startIO after a programmable delay, captures CPU     |
// |            output words into a circular buffer and drains them through a   |
// |            valid/ready stream until a programmable word count is reached.  |
// | Options  : OUTCAPTURE_TIMESTAMP_EN - store a free-running cycle stamp with |
// |            each word and present it as dataTimestamp.                      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module out_capture_unit
  import out_capture_pkg::*;
#(
  parameter int unsigned WIDTH         = c_defaultWidth,
  parameter int unsigned DEPTH         = c_defaultDepth,
  parameter int unsigned COUNTWIDTH    = c_defaultCountWidth,
  parameter int unsigned START_DELAY   = c_defaultStartDelay,
  parameter int unsigned CAPTURE_LIMIT = c_defaultCaptureLimit
) (
  input  wire logic                  clock,
  input  wire logic                  reset,
  out_capture_unit_if.master         bus,
  output logic                       startIO,
  output logic [COUNTWIDTH-1:0]      capturedCount,
  output logic [COUNTWIDTH-1:0]      droppedCount,
  output logic                       overflow,
  output logic                       done
);

  localparam logic [COUNTWIDTH-1:0] c_delayLast = COUNTWIDTH'(START_DELAY - 1);
  localparam logic [COUNTWIDTH-1:0] c_limitLast = COUNTWIDTH'(CAPTURE_LIMIT - 1);
`ifdef OUTCAPTURE_TIMESTAMP_EN
  localparam int unsigned c_entryWidth = WIDTH + COUNTWIDTH;
`else
  localparam int unsigned c_entryWidth = WIDTH;
`endif

  captureState_t           r_state;
  logic [COUNTWIDTH-1:0]   r_delayCount;
  logic [COUNTWIDTH-1:0]   r_capturedCount;
  logic [COUNTWIDTH-1:0]   r_droppedCount;
  logic                    r_startIO;
  logic                    r_overflow;
  logic                    r_done;

  logic                    w_full;
  logic                    w_empty;
  logic                    w_pop;
  logic                    w_capture;
  logic                    w_push;
  logic                    w_drop;
  logic [c_entryWidth-1:0] w_pushData;
  logic [c_entryWidth-1:0] w_headData;
  logic [$clog2(DEPTH):0]  w_occupancy;

  // A full buffer still accepts a word when the consumer frees the head slot
  assign w_pop     = !w_empty && bus.dataReady;
  assign w_capture = (r_state == RUN) && bus.outFlag;
  assign w_push    = w_capture && (!w_full || w_pop);
  assign w_drop    = w_capture && w_full && !w_pop;

`ifdef OUTCAPTURE_TIMESTAMP_EN
  logic [COUNTWIDTH-1:0] r_cycleCount;

  // Free-running capture timestamp, cleared only by reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cycleCount <= '0;
    end else begin
      r_cycleCount <= r_cycleCount + 1'b1;
    end
  end

  assign w_pushData        = {r_cycleCount, bus.out};
  assign bus.dataTimestamp = w_headData[WIDTH +: COUNTWIDTH];
`else
  assign w_pushData = bus.out;
`endif

  capture_fifo #(
    .WIDTH (c_entryWidth),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (w_push),
    .pushData  (w_pushData),
    .pop       (w_pop),
    .full      (w_full),
    .empty     (w_empty),
    .headData  (w_headData),
    .occupancy (w_occupancy)
  );

  // Phase control: start delay, capture counting and terminal done flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state         <= WAIT;
      r_delayCount    <= '0;
      r_capturedCount <= '0;
      r_startIO       <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      case (r_state)
        WAIT: begin
          r_delayCount <= r_delayCount + 1'b1;
          if (r_delayCount == c_delayLast) begin
            r_state   <= RUN;
            r_startIO <= 1'b1;
          end
        end
        RUN: begin
          if (w_push) begin
            r_capturedCount <= r_capturedCount + 1'b1;
            if (r_capturedCount == c_limitLast) begin
              r_state <= FINISH;
            end
          end
        end
        FINISH: begin
          if (w_occupancy == '0) begin
            r_done <= 1'b1;
          end
        end
        default: begin
          r_state <= WAIT;
        end
      endcase
    end
  end

  // Saturating drop counter and sticky overflow flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_droppedCount <= '0;
      r_overflow     <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_droppedCount != '1) begin
        r_droppedCount <= r_droppedCount + 1'b1;
      end
    end
  end

  assign bus.dataValid = !w_empty;
  assign bus.dataOut   = w_headData[WIDTH-1:0];
  assign startIO       = r_startIO;
  assign capturedCount = r_capturedCount;
  assign droppedCount  = r_droppedCount;
  assign overflow      = r_overflow;
  assign done          = r_done;

endmodule : out_capture_unit
`default_nettype wire

// File: tb/tb_out_capture_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_out_capture_unit                                             |
// | Purpose  : Directed self-checking bench with a scoreboard queue for the    |
// |            CPU output capture unit.                                        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_out_capture_unit;

  localparam int WIDTH         = 36;
  localparam int DEPTH         = 16;
  localparam int COUNTWIDTH    = 16;
  localparam int START_DELAY   = 10;
  localparam int CAPTURE_LIMIT = 668;

  logic                  clock;
  logic                  reset;
  logic                  startIO;
  logic [COUNTWIDTH-1:0] capturedCount;
  logic [COUNTWIDTH-1:0] droppedCount;
  logic                  overflow;
  logic                  done;

  out_capture_unit_if bus ();

  out_capture_unit #(
    .WIDTH         (WIDTH),
    .DEPTH         (DEPTH),
    .COUNTWIDTH    (COUNTWIDTH),
    .START_DELAY   (START_DELAY),
    .CAPTURE_LIMIT (CAPTURE_LIMIT)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .bus           (bus.master),
    .startIO       (startIO),
    .capturedCount (capturedCount),
    .droppedCount  (droppedCount),
    .overflow      (overflow),
    .done          (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [WIDTH-1:0]      expQ[$];
  logic [COUNTWIDTH-1:0] tsQ[$];
  int                    cyc;
  bit                    mFinished;
  int                    mCap;
  int                    mDrop;
  bit                    mOvf;
  bit                    mDone;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelClear();
    expQ.delete();
    tsQ.delete();
    cyc       = 0;
    mFinished = 0;
    mCap      = 0;
    mDrop     = 0;
    mOvf      = 0;
    mDone     = 0;
  endtask

  // one clock: drive at negedge, check just after, predict, advance to next negedge
  task automatic step(input bit f, input logic [WIDTH-1:0] w, input bit r);
    bit popNow;
    bit nextDone;
    bit run;
    int sizeBefore;
    bus.outFlag   = f;
    bus.out       = w;
    bus.dataReady = r;
    #1;
    check("startIO", startIO, (cyc >= START_DELAY));
    check("dataValid", bus.dataValid, (expQ.size() != 0));
    check("capturedCount", capturedCount, mCap);
    check("droppedCount", droppedCount, mDrop);
    check("overflow", overflow, mOvf);
    check("done", done, mDone);
    sizeBefore = expQ.size();
    nextDone   = mDone || (mFinished && sizeBefore == 0);
    popNow     = (sizeBefore != 0) && r;
    if (popNow) begin
      check("dataOut", bus.dataOut, expQ[0]);
`ifdef OUTCAPTURE_TIMESTAMP_EN
      check("dataTimestamp", bus.dataTimestamp, tsQ[0]);
`endif
      void'(expQ.pop_front());
      void'(tsQ.pop_front());
    end
    run = (cyc >= START_DELAY) && !mFinished;
    if (run && f) begin
      if (sizeBefore < DEPTH || popNow) begin
        expQ.push_back(w);
        tsQ.push_back(COUNTWIDTH'(cyc));
        mCap++;
        if (mCap == CAPTURE_LIMIT) mFinished = 1;
      end else begin
        if (mDrop < (1 << COUNTWIDTH) - 1) mDrop++;
        mOvf = 1;
      end
    end
    mDone = nextDone;
    @(posedge clock);
    cyc++;
    @(negedge clock);
  endtask

  initial begin
    int guard;
    int n;
    bus.outFlag   = 1'b0;
    bus.out       = '0;
    bus.dataReady = 1'b0;
    reset         = 1'b0;
    modelClear();

    // reset values
    repeat (2) @(negedge clock);
    #1;
    check("rst_startIO", startIO, 0);
    check("rst_dataValid", bus.dataValid, 0);
    check("rst_overflow", overflow, 0);
    check("rst_done", done, 0);
    check("rst_captured", capturedCount, 0);
    check("rst_dropped", droppedCount, 0);
    @(negedge clock);
    reset = 1'b1;

    // start delay with outFlag held high: nothing captured while waiting
    for (int i = 0; i < START_DELAY; i++) step(1'b1, WIDTH'(36'hABC), 1'b0);
    check("delay_startIO", startIO, 1);
    check("delay_captured", capturedCount, 0);

    // five spaced words drained immediately
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, WIDTH'(i), 1'b1);
      step(1'b0, '0, 1'b1);
    end
    step(1'b0, '0, 1'b1);
    check("five_captured", capturedCount, 5);
    check("five_overflow", overflow, 0);

    // 20 words with consumer stalled: 16 stored, 4 dropped
    for (int i = 0; i < 20; i++) step(1'b1, WIDTH'(36'h100 + i), 1'b0);
    check("fill_dropped", droppedCount, 4);
    check("fill_overflow", overflow, 1);
    check("fill_captured", capturedCount, 21);

    // full buffer with simultaneous read: write accepted
    step(1'b1, WIDTH'(36'h200), 1'b1);
    check("fullrw_dropped", droppedCount, 4);
    check("fullrw_captured", capturedCount, 22);

    // drain: exactly 16 entries remain, overflow stays sticky
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1);
    check("drain_valid", bus.dataValid, 0);
    check("drain_overflow", overflow, 1);

    // continuous capture up to the limit, then extra words ignored
    guard = 0;
    n = 0;
    while (!mFinished && guard < 2000) begin
      step(1'b1, WIDTH'(36'h300 + n), 1'b1);
      n++;
      guard++;
    end
    if (guard >= 2000) check("limit_timeout", 1, 0);
    for (int i = 0; i < 5; i++) step(1'b1, WIDTH'(36'hF00 + i), 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
    check("limit_captured", capturedCount, CAPTURE_LIMIT);
    check("limit_done", done, 1);
    check("limit_valid", bus.dataValid, 0);

    // mid-run reset with 7 entries buffered
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    modelClear();
    for (int i = 0; i < START_DELAY; i++) step(1'b0, '0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, WIDTH'(36'h400 + i), 1'b0);
    check("pre_rst_captured", capturedCount, 7);
    #2;
    reset = 1'b0;
    #1;
    check("async_dataValid", bus.dataValid, 0);
    check("async_startIO", startIO, 0);
    check("async_captured", capturedCount, 0);
    check("async_dropped", droppedCount, 0);
    check("async_done", done, 0);
    @(negedge clock);
    reset = 1'b1;
    modelClear();
    for (int i = 0; i < START_DELAY + 3; i++) step(1'b0, '0, 1'b1);
    check("restart_startIO", startIO, 1);
    check("restart_valid", bus.dataValid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_out_capture_unit
`default_nettype wire
